// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a two-entry skid buffer,
// synchronous flush and a saturating back-pressure stall counter.
module pipe_stage_elastic #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned CTRL_W = 5,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic [ADDR_W-1:0] addr_o,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [ADDR_W-1:0] addr;
        logic [CTRL_W-1:0] ctrl;
    } entry_t;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] STALL_MAX = '1;

    state_e           state_q, state_d;
    entry_t           main_q, main_d;
    entry_t           skid_q, skid_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    entry_t           in_entry;
    logic             in_fire, out_fire;

    assign in_entry    = {data_i, addr_i, ctrl_i};
    // Handshake outputs decode the registered state only.
    assign in_ready_o  = (state_q != ST_FULL);
    assign out_valid_o = (state_q != ST_EMPTY);
    assign in_fire     = in_valid_i & in_ready_o;
    assign out_fire    = out_valid_o & out_ready_i;

    assign data_o      = main_q.data;
    assign addr_o      = main_q.addr;
    assign ctrl_o      = out_valid_o ? main_q.ctrl : '0;
    assign stall_cnt_o = stall_q;

    // State register and storage.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
            stall_q <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        stall_d = stall_q;

        if (out_valid_o && !out_ready_i && (stall_q != STALL_MAX)) begin
            stall_d = stall_q + CNT_W'(1);
        end

        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        state_d = ST_ONE;
                        main_d  = in_entry;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_entry;
                    end else if (in_fire) begin
                        state_d = ST_FULL;
                        skid_d  = in_entry;
                    end else if (out_fire) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Bench for pipe_stage_elastic: directed vector table, saturation and async-reset
// sequences, then random traffic against a queue-based reference model.
module tb_pipe_stage_elastic;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 5;
    localparam int unsigned NW = 4;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          flush_i, in_valid_i, in_ready_o, out_valid_o, out_ready_i;
    logic [DW-1:0] data_i, data_o;
    logic [AW-1:0] addr_i, addr_o;
    logic [CW-1:0] ctrl_i, ctrl_o;
    logic [NW-1:0] stall_cnt_o;

    int errs   = 0;
    int checks = 0;

    pipe_stage_elastic #(.DATA_W(DW), .ADDR_W(AW), .CTRL_W(CW), .CNT_W(NW)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
        .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .data_i(data_i), .addr_i(addr_i), .ctrl_i(ctrl_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .data_o(data_o), .addr_o(addr_o), .ctrl_o(ctrl_o),
        .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic          fl, vin, ordy;
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        logic          ev, er;
        logic [DW-1:0] ed;
        logic [CW-1:0] ec;
        logic [NW-1:0] es;
    } vec_t;

    vec_t tbl[13];

    // Reference model: FIFO of at most two entries plus a saturating counter.
    typedef struct packed {
        logic [DW-1:0] d;
        logic [AW-1:0] a;
        logic [CW-1:0] c;
    } ent_t;
    ent_t m_q[$];
    int   m_stall = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic fl, input logic vin, input logic ordy,
                         input logic [DW-1:0] d, input logic [CW-1:0] c);
        flush_i     = fl;
        in_valid_i  = vin;
        out_ready_i = ordy;
        data_i      = d;
        addr_i      = d[AW-1:0];
        ctrl_i      = c;
    endtask

    // Advance one edge, updating the model from the pre-edge inputs and contents.
    task automatic step();
        bit m_ovalid, m_iready, ifire, ofire;
        ent_t e;
        m_ovalid = (m_q.size() > 0);
        m_iready = (m_q.size() < 2);
        ifire    = in_valid_i && m_iready;
        ofire    = m_ovalid && out_ready_i;
        e        = '{d: data_i, a: addr_i, c: ctrl_i};
        @(posedge clk_i);
        if (m_ovalid && !out_ready_i && m_stall < (1 << NW) - 1) m_stall++;
        if (flush_i) m_q.delete();
        else begin
            if (ofire) void'(m_q.pop_front());
            if (ifire) m_q.push_back(e);
        end
        #1;
    endtask

    task automatic check_model(input string nm);
        chk({nm, "_valid"}, 64'(out_valid_o), 64'(m_q.size() > 0));
        chk({nm, "_ready"}, 64'(in_ready_o), 64'(m_q.size() < 2));
        chk({nm, "_stall"}, 64'(stall_cnt_o), 64'(m_stall));
        if (m_q.size() > 0) begin
            chk({nm, "_head"}, 64'({data_o, addr_o, ctrl_o}), 64'(m_q[0]));
        end else begin
            chk({nm, "_bubble_ctrl"}, 64'(ctrl_o), 64'd0);
        end
    endtask

    initial begin
        //             fl vin ordy data        ctrl    ev er exp_data    ec      es
        tbl[0]  = '{1'b0,1'b1,1'b1,32'h1, 5'h03, 1'b1,1'b1,32'h1, 5'h03, 4'd0};
        tbl[1]  = '{1'b0,1'b1,1'b1,32'h2, 5'h03, 1'b1,1'b1,32'h2, 5'h03, 4'd0};
        tbl[2]  = '{1'b0,1'b1,1'b1,32'h3, 5'h06, 1'b1,1'b1,32'h3, 5'h06, 4'd0};
        tbl[3]  = '{1'b0,1'b1,1'b0,32'hA, 5'h04, 1'b1,1'b0,32'h3, 5'h06, 4'd1};
        tbl[4]  = '{1'b0,1'b1,1'b0,32'hB, 5'h05, 1'b1,1'b0,32'h3, 5'h06, 4'd2};
        tbl[5]  = '{1'b0,1'b1,1'b1,32'hB, 5'h05, 1'b1,1'b1,32'hA, 5'h04, 4'd2};
        tbl[6]  = '{1'b0,1'b1,1'b1,32'hB, 5'h05, 1'b1,1'b1,32'hB, 5'h05, 4'd2};
        tbl[7]  = '{1'b0,1'b0,1'b0,32'h0, 5'h00, 1'b1,1'b1,32'hB, 5'h05, 4'd3};
        tbl[8]  = '{1'b0,1'b1,1'b0,32'hC, 5'h1F, 1'b1,1'b0,32'hB, 5'h05, 4'd4};
        tbl[9]  = '{1'b1,1'b1,1'b0,32'hD, 5'h07, 1'b0,1'b1,32'h0, 5'h00, 4'd5};
        tbl[10] = '{1'b0,1'b0,1'b1,32'h0, 5'h00, 1'b0,1'b1,32'h0, 5'h00, 4'd5};
        tbl[11] = '{1'b0,1'b1,1'b0,32'hE, 5'h1F, 1'b1,1'b1,32'hE, 5'h1F, 4'd5};
        tbl[12] = '{1'b0,1'b0,1'b1,32'h0, 5'h00, 1'b0,1'b1,32'h0, 5'h00, 4'd5};

        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        #2;
        chk("reset_outputs", 64'({out_valid_o, in_ready_o, ctrl_o, stall_cnt_o}),
            64'({1'b0, 1'b1, 5'h00, 4'd0}));
        chk("reset_data", 64'({data_o, addr_o}), 64'd0);
        #10 rst_i = 1'b1;

        // Directed vectors: streaming, back-pressure, flush, bubble ctrl.
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].fl, tbl[i].vin, tbl[i].ordy, tbl[i].d, tbl[i].c);
            step();
            chk($sformatf("vec%0d_ctl", i),
                64'({out_valid_o, in_ready_o, ctrl_o, stall_cnt_o}),
                64'({tbl[i].ev, tbl[i].er, tbl[i].ec, tbl[i].es}));
            if (tbl[i].ev) begin
                chk($sformatf("vec%0d_data", i), 64'({data_o, addr_o}),
                    64'({tbl[i].ed, tbl[i].ed[AW-1:0]}));
            end
        end

        // Saturation: fill and stall for 20 cycles; counter rises from 5 and sticks at 15.
        drive(1'b0, 1'b1, 1'b0, 32'h55, 5'h09);
        for (int i = 0; i < 20; i++) step();
        chk("sat_stall", 64'(stall_cnt_o), 64'd15);
        chk("sat_full_ready", 64'(in_ready_o), 64'd0);

        // Async reset mid-cycle while FULL: outputs clear with no clock edge.
        #3 rst_i = 1'b0;
        #1;
        chk("areset_ctl", 64'({out_valid_o, in_ready_o, ctrl_o, stall_cnt_o}),
            64'({1'b0, 1'b1, 5'h00, 4'd0}));
        chk("areset_data", 64'({data_o, addr_o}), 64'd0);
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        m_q.delete();
        m_stall = 0;
        @(negedge clk_i);
        rst_i = 1'b1;

        // Random traffic against the reference model.
        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 3) != 0), $urandom(), CW'($urandom()));
            step();
            check_model("rand");
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
